fetch_predict_unit: RTL

- Parametrised instruction-fetch front end for the pipelined processor; successor to the single-cycle PC/PC+4/BTA path.
- Owns the PC register and drives the instruction-memory address.
- Predicts BEQ/JAL targets using a bimodal table of 2-bit saturating counters.
- Presents the fetched instruction to the IF/ID boundary, and takes redirect/update traffic from the EX-stage branch resolution.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/branch_history_table.sv | 34 +++
 rtl/fetch_predict_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared opcode constants, 2-bit counter encodings and immediate decoders
// for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Bimodal table of 2-bit saturating counters: async read, synchronous
// saturating update, async reset to weakly-not-taken.
module branch_history_table
  import fetch_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output cnt_t             rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  cnt_t tbl [ENTRIES];

  assign rd_cnt = tbl[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl[i] <= WNT;
    end else if (wr_en) begin
      if (wr_taken) begin
        if (tbl[wr_idx] != ST) tbl[wr_idx] <= cnt_t'(tbl[wr_idx] + 2'd1);
      end else begin
        if (tbl[wr_idx] != SNT) tbl[wr_idx] <= cnt_t'(tbl[wr_idx] - 2'd1);
      end
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// Instruction-fetch front end: PC register, BEQ/JAL predecode with bimodal
// prediction, IF/ID register, EX-stage redirect and mispredict counter.
module fetch_predict_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BHT_ENTRIES = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic             res_taken,
  input  logic             res_mispredict,
  input  logic [XLEN-1:0]  res_target,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [31:0]      id_instr,
  output logic             id_pred_taken,
  output logic [XLEN-1:0]  id_pred_target,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0]  pc;
  cnt_t             rd_cnt;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]  imm_ext;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             unused_res_pc;

  assign imem_addr     = pc;
  assign lookup_idx    = pc[IDX_W+1:2];
  assign update_idx    = res_pc[IDX_W+1:2];
  assign unused_res_pc = ^{res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

  branch_history_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (reset),
    .rd_idx   (lookup_idx),
    .rd_cnt   (rd_cnt),
    .wr_en    (res_valid),
    .wr_idx   (update_idx),
    .wr_taken (res_taken)
  );

  always_comb begin
    imm32      = '0;
    pred_taken = 1'b0;
    if (imem_rdata[6:0] == OP_BRANCH && imem_rdata[14:12] == F3_BEQ) begin
      imm32      = b_imm(imem_rdata);
      pred_taken = rd_cnt[1];
    end else if (imem_rdata[6:0] == OP_JAL) begin
      imm32      = j_imm(imem_rdata);
      pred_taken = 1'b1;
    end
  end

  // Signed cast sign-extends the 32-bit immediate to XLEN.
  assign imm_ext     = XLEN'(imm32);
  assign pred_target = pred_taken ? pc + imm_ext : pc + XLEN'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc             <= RESET_PC;
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_instr       <= '0;
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
    end else if (res_mispredict) begin
      pc       <= res_target;
      id_valid <= 1'b0;
    end else if (!stall) begin
      pc             <= pred_target;
      id_valid       <= 1'b1;
      id_pc          <= pc;
      id_instr       <= imem_rdata;
      id_pred_taken  <= pred_taken;
      id_pred_target <= pred_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (res_mispredict && mispredict_count != '1) begin
      mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule
